// File: rtl/spi_slv_pkg.sv
// -----------------------------------------------------------------------------
// spi_slv_pkg
// Shared definitions for the SPI slave with TX/RX word FIFOs:
//   - default word width and FIFO depths
//   - tx_act_e : per-cycle action of the TX shifter (load a new word / shift)
//   - clog2()  : ceiling log2 used for counter and pointer widths
//   - out_bit_idx() : index of the bit that leaves the shifter first,
//                     selected by the bit order
// Optional feature macro used elsewhere in this slice: SPI_SLAVE_STATUS_EN.
// -----------------------------------------------------------------------------
package spi_slv_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_TX_DEPTH  = 4;
  localparam int DEF_RX_DEPTH  = 4;
  localparam int DEF_MSB_FIRST = 1;

  typedef enum logic {
    TX_SHIFT = 1'b0,
    TX_LOAD  = 1'b1
  } tx_act_e;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      res = res + 1;
    end
    return res;
  endfunction

  function automatic int out_bit_idx(input int width, input int msb_first);
    return (msb_first != 0) ? (width - 1) : 0;
  endfunction

endpackage

// File: rtl/spi_slave_fifo_if.sv
// -----------------------------------------------------------------------------
// spi_slave_fifo_if
// Local-side word handshakes of the SPI slave.
//   tx_data/tx_valid/tx_ready : words to transmit (pushed when valid && ready)
//   rx_data/rx_valid/rx_ready : received words (popped when valid && ready)
// Modports: slave (the SPI slave block), master (the local logic).
// -----------------------------------------------------------------------------
interface spi_slave_fifo_if
  import spi_slv_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;

  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_valid
  );

  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_valid
  );
endinterface

// File: rtl/spi_slv_fifo.sv
// -----------------------------------------------------------------------------
// spi_slv_fifo
// Synchronous word FIFO, one clock (sclk), synchronous active-low reset.
//   push_i/push_data_i : write; ignored when full unless a pop happens too
//   pop_i              : read; ignored when empty
//   full_o/empty_o     : occupancy flags
//   head_o             : oldest entry (storage is cleared on reset, so the
//                        head reads as zero after reset)
// -----------------------------------------------------------------------------
module spi_slv_fifo
  import spi_slv_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_W,
  parameter int DEPTH = DEF_TX_DEPTH
) (
  input  logic             sclk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push_s;
  logic             do_pop_s;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Push/pop qualification and pointer next-state.
  always_comb begin
    do_pop_s  = pop_i && !empty_o;
    // A push into a full FIFO is accepted when a pop frees a slot in the same cycle.
    do_push_s = push_i && (!full_o || do_pop_s);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Pointer and storage registers.
  always_ff @(posedge sclk) begin
    if (!reset) begin
      wr_ptr_q <= {(AW + 1){1'b0}};
      rd_ptr_q <= {(AW + 1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (do_push_s) begin
        mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
      end
    end
  end

endmodule

// File: rtl/spi_slave_fifo.sv
// -----------------------------------------------------------------------------
// spi_slave_fifo
// SPI mode-0 slave with TX and RX word FIFOs on the local side. Everything
// runs in the free-running sclk domain; miso changes on the falling edge so
// the master samples bit k of a word on rising edge k of that word.
// Ports:
//   sclk, reset   clock; synchronous active-low reset
//   cs_n, mosi    chip select (active low) and serial data in, sampled on posedge
//   miso          serial data out, updated on negedge
//   busy          high while cs_n=0 and a word is partly shifted
//   bus (slave)   tx_data/tx_valid/tx_ready, rx_data/rx_valid/rx_ready
// Optional (macro SPI_SLAVE_STATUS_EN):
//   rx_overflow   sticky: an RX word was dropped
//   tx_underrun   sticky: a word started with nothing loaded from the TX FIFO
//   status_clr    clears both flags; a set event in the same cycle wins
// -----------------------------------------------------------------------------
module spi_slave_fifo
  import spi_slv_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int TX_DEPTH  = DEF_TX_DEPTH,
  parameter int RX_DEPTH  = DEF_RX_DEPTH,
  parameter int MSB_FIRST = DEF_MSB_FIRST
) (
  input  logic            sclk,
  input  logic            reset,
  input  logic            cs_n,
  input  logic            mosi,
  output logic            miso,
  spi_slave_fifo_if.slave bus,
  output logic            busy
`ifdef SPI_SLAVE_STATUS_EN
  ,
  output logic            rx_overflow,
  output logic            tx_underrun,
  input  logic            status_clr
`endif
);

  localparam int              CW       = clog2(DATA_W);
  localparam logic [CW-1:0]   LAST_BIT = CW'(DATA_W - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam int              OUT_IDX  = out_bit_idx(DATA_W, MSB_FIRST);

  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic              tx_vld_q, tx_vld_d;
  logic              miso_q;

  logic              word_start_s;
  logic              word_last_s;
  tx_act_e           tx_act_s;

  logic              rx_push_s, rx_pop_s, rx_full_s, rx_empty_s;
  logic [DATA_W-1:0] rx_head_s;
  logic              tx_push_s, tx_pop_s, tx_full_s, tx_empty_s;
  logic [DATA_W-1:0] tx_head_s;

  spi_slv_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .sclk       (sclk),
    .reset      (reset),
    .push_i     (tx_push_s),
    .push_data_i(bus.tx_data),
    .pop_i      (tx_pop_s),
    .full_o     (tx_full_s),
    .empty_o    (tx_empty_s),
    .head_o     (tx_head_s)
  );

  spi_slv_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .sclk       (sclk),
    .reset      (reset),
    .push_i     (rx_push_s),
    .push_data_i(rx_shift_d),
    .pop_i      (rx_pop_s),
    .full_o     (rx_full_s),
    .empty_o    (rx_empty_s),
    .head_o     (rx_head_s)
  );

  assign bus.tx_ready = !tx_full_s;
  assign bus.rx_valid = !rx_empty_s;
  assign bus.rx_data  = rx_head_s;
  assign busy         = !cs_n && (bit_cnt_q != {CW{1'b0}});
  assign miso         = miso_q;

  // Word framing, FIFO handshakes and shifter next-state.
  always_comb begin
    word_start_s = !cs_n && (bit_cnt_q == {CW{1'b0}});
    word_last_s  = !cs_n && (bit_cnt_q == LAST_BIT);
    tx_push_s    = bus.tx_valid && !tx_full_s;
    rx_pop_s     = bus.rx_ready && !rx_empty_s;
    // The completed word includes the bit sampled on this edge.
    rx_push_s    = word_last_s;
    // The loaded word leaves the FIFO only once it actually starts shifting.
    tx_pop_s     = word_start_s && tx_vld_q;

    if (cs_n) begin
      bit_cnt_d = {CW{1'b0}};
    end else if (bit_cnt_q == LAST_BIT) begin
      bit_cnt_d = {CW{1'b0}};
    end else begin
      bit_cnt_d = bit_cnt_q + CNT_ONE;
    end

    // A deselect discards any partial word.
    if (cs_n) begin
      rx_shift_d = {DATA_W{1'b0}};
    end else if (MSB_FIRST != 0) begin
      rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi};
    end else begin
      rx_shift_d = {mosi, rx_shift_q[DATA_W-1:1]};
    end

    // Preload while idle and on the last bit so back-to-back words have no gap.
    if (cs_n || (bit_cnt_q == LAST_BIT)) begin
      tx_act_s = TX_LOAD;
    end else begin
      tx_act_s = TX_SHIFT;
    end

    case (tx_act_s)
      TX_LOAD: begin
        tx_shift_d = tx_empty_s ? {DATA_W{1'b0}} : tx_head_s;
        tx_vld_d   = !tx_empty_s;
      end
      TX_SHIFT: begin
        if (MSB_FIRST != 0) begin
          tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
        end else begin
          tx_shift_d = {1'b0, tx_shift_q[DATA_W-1:1]};
        end
        tx_vld_d = tx_vld_q;
      end
      default: begin
        tx_shift_d = tx_shift_q;
        tx_vld_d   = tx_vld_q;
      end
    endcase
  end

  // Bit counter and shifter registers.
  always_ff @(posedge sclk) begin
    if (!reset) begin
      bit_cnt_q  <= {CW{1'b0}};
      rx_shift_q <= {DATA_W{1'b0}};
      tx_shift_q <= {DATA_W{1'b0}};
      tx_vld_q   <= 1'b0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      tx_vld_q   <= tx_vld_d;
    end
  end

  // Outgoing bit is launched on the falling edge, half a cycle before the master samples it.
  always_ff @(negedge sclk) begin
    if (!reset) begin
      miso_q <= 1'b0;
    end else begin
      miso_q <= tx_shift_q[OUT_IDX];
    end
  end

`ifdef SPI_SLAVE_STATUS_EN
  logic rx_overflow_q, rx_overflow_d;
  logic tx_underrun_q, tx_underrun_d;

  // Sticky status next-state; a set event overrides a clear in the same cycle.
  always_comb begin
    if (rx_push_s && rx_full_s && !rx_pop_s) begin
      rx_overflow_d = 1'b1;
    end else if (status_clr) begin
      rx_overflow_d = 1'b0;
    end else begin
      rx_overflow_d = rx_overflow_q;
    end
    if (word_start_s && !tx_vld_q) begin
      tx_underrun_d = 1'b1;
    end else if (status_clr) begin
      tx_underrun_d = 1'b0;
    end else begin
      tx_underrun_d = tx_underrun_q;
    end
  end

  // Sticky status registers.
  always_ff @(posedge sclk) begin
    if (!reset) begin
      rx_overflow_q <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      rx_overflow_q <= rx_overflow_d;
      tx_underrun_q <= tx_underrun_d;
    end
  end

  assign rx_overflow = rx_overflow_q;
  assign tx_underrun = tx_underrun_q;
`endif

endmodule

// File: tb/tb_spi_slave_fifo.sv
// Self-checking bench: 8-bit MSB-first instance for most scenarios, plus a
// 16-bit LSB-first instance. Status flag checks compile in with SPI_SLAVE_STATUS_EN.
module tb_spi_slave_fifo;
  import spi_slv_pkg::*;

  logic sclk = 1'b0;
  always #5 sclk = ~sclk;

  logic reset, cs_n, mosi, miso, busy;
  logic cs2_n, mosi2, miso2, busy2;
`ifdef SPI_SLAVE_STATUS_EN
  logic rx_ovf, tx_und, st_clr;
  logic rx_ovf2, tx_und2, st_clr2;
`endif

  spi_slave_fifo_if #(.DATA_W(8))  bus8 ();
  spi_slave_fifo_if #(.DATA_W(16)) bus16 ();

  spi_slave_fifo #(.DATA_W(8), .TX_DEPTH(4), .RX_DEPTH(4), .MSB_FIRST(1)) dut (
    .sclk(sclk), .reset(reset), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .bus(bus8), .busy(busy)
`ifdef SPI_SLAVE_STATUS_EN
    , .rx_overflow(rx_ovf), .tx_underrun(tx_und), .status_clr(st_clr)
`endif
  );

  spi_slave_fifo #(.DATA_W(16), .TX_DEPTH(4), .RX_DEPTH(4), .MSB_FIRST(0)) dut16 (
    .sclk(sclk), .reset(reset), .cs_n(cs2_n), .mosi(mosi2), .miso(miso2),
    .bus(bus16), .busy(busy2)
`ifdef SPI_SLAVE_STATUS_EN
    , .rx_overflow(rx_ovf2), .tx_underrun(tx_und2), .status_clr(st_clr2)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: words waiting to be sent / received, sticky flags.
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  bit ovf_m, und_m;

  typedef struct {
    int         frame;
    bit         has_tx;
    logic [7:0] tx;
    logic [7:0] mosi_w;
    logic [7:0] exp_miso;
    logic [7:0] exp_rx;
  } vec_t;
  vec_t vec[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge sclk);
    #1;
  endtask

  task automatic push_tx(input logic [7:0] d);
    tick();
    bus8.tx_valid = 1'b1;
    bus8.tx_data  = d;
    tick();
    bus8.tx_valid = 1'b0;
  endtask

  // One 8-bit word, MSB first; returns the bits seen on miso.
  task automatic send_word(input logic [7:0] m, input bit pop_last, output logic [7:0] got);
    for (int i = 0; i < 8; i++) begin
      tick();
      cs_n = 1'b0;
      mosi = m[7-i];
      bus8.rx_ready = pop_last && (i == 7);
      got[7-i] = miso;
    end
  endtask

  task automatic end_frame();
    tick();
    cs_n = 1'b1;
    mosi = 1'b0;
    bus8.rx_ready = 1'b0;
  endtask

  task automatic pop_check(input string name, input logic [7:0] exp);
    tick();
    chk({name, "_valid"}, {31'd0, bus8.rx_valid}, 32'd1);
    chk({name, "_data"}, {24'd0, bus8.rx_data}, {24'd0, exp});
    bus8.rx_ready = 1'b1;
    tick();
    bus8.rx_ready = 1'b0;
  endtask

`ifdef SPI_SLAVE_STATUS_EN
  task automatic clear_status();
    tick();
    st_clr = 1'b1;
    tick();
    st_clr = 1'b0;
  endtask
`endif

  initial begin
    logic [7:0]  got;
    logic [7:0]  mw;
    logic [15:0] got16;
    logic [15:0] rxw16;
    int i, j;

    vec[0] = '{0, 1'b1, 8'h0F, 8'hF0, 8'h0F, 8'hF0};
    vec[1] = '{1, 1'b1, 8'h11, 8'h81, 8'h11, 8'h81};
    vec[2] = '{1, 1'b1, 8'h22, 8'h42, 8'h22, 8'h42};
    vec[3] = '{1, 1'b1, 8'h33, 8'h24, 8'h33, 8'h24};
    vec[4] = '{2, 1'b0, 8'h00, 8'h7E, 8'h00, 8'h7E};
    vec[5] = '{3, 1'b1, 8'h80, 8'h01, 8'h80, 8'h01};
    vec[6] = '{3, 1'b0, 8'h00, 8'hFF, 8'h00, 8'hFF};

    reset = 1'b0; cs_n = 1'b1; mosi = 1'b0; cs2_n = 1'b1; mosi2 = 1'b0;
    bus8.tx_valid = 1'b0; bus8.tx_data = 8'h00; bus8.rx_ready = 1'b0;
    bus16.tx_valid = 1'b0; bus16.tx_data = 16'h0000; bus16.rx_ready = 1'b0;
`ifdef SPI_SLAVE_STATUS_EN
    st_clr = 1'b0; st_clr2 = 1'b0;
`endif
    repeat (3) tick();
    chk("rst_tx_ready", {31'd0, bus8.tx_ready}, 32'd1);
    chk("rst_rx_valid", {31'd0, bus8.rx_valid}, 32'd0);
    chk("rst_rx_data", {24'd0, bus8.rx_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_miso", {31'd0, miso}, 32'd0);
    reset = 1'b1;
    tick();

    // Full duplex A5 out, 3C in, with latency and busy checks.
    push_tx(8'hA5);
    tick();
    mw = 8'h3C;
    for (int b = 0; b < 8; b++) begin
      tick();
      cs_n = 1'b0;
      mosi = mw[7-b];
      got[7-b] = miso;
      #1;
      if (b == 4) chk("busy_mid_word", {31'd0, busy}, 32'd1);
      if (b == 7) chk("rx_valid_before_last", {31'd0, bus8.rx_valid}, 32'd0);
    end
    tick();
    chk("t2_miso", {24'd0, got}, 32'hA5);
    chk("t2_rx_valid", {31'd0, bus8.rx_valid}, 32'd1);
    chk("t2_rx_data", {24'd0, bus8.rx_data}, 32'h3C);
    chk("busy_word_end", {31'd0, busy}, 32'd0);
    end_frame();
    pop_check("t2_pop", 8'h3C);

    // Table-driven frames.
    i = 0;
    while (i < 7) begin
      j = i;
      while (j < 7 && vec[j].frame == vec[i].frame) begin
        if (vec[j].has_tx) push_tx(vec[j].tx);
        j++;
      end
      tick(); tick();
      for (int k = i; k < j; k++) begin
        send_word(vec[k].mosi_w, 1'b0, got);
        chk("vec_miso", {24'd0, got}, {24'd0, vec[k].exp_miso});
      end
      end_frame();
      for (int k = i; k < j; k++) pop_check("vec_rx", vec[k].exp_rx);
      tick();
      chk("vec_rx_empty", {31'd0, bus8.rx_valid}, 32'd0);
      i = j;
    end

    // Reset held mid-frame clears everything, including queued TX words.
    push_tx(8'hA1);
    push_tx(8'hB2);
    tick(); tick();
    for (int b = 0; b < 3; b++) begin
      tick(); cs_n = 1'b0; mosi = 1'b1;
    end
    tick();
    reset = 1'b0;
    repeat (3) tick();
    chk("mid_rst_tx_ready", {31'd0, bus8.tx_ready}, 32'd1);
    chk("mid_rst_rx_valid", {31'd0, bus8.rx_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_miso", {31'd0, miso}, 32'd0);
    cs_n = 1'b1;
    tick();
    reset = 1'b1;
    tick(); tick();
    send_word(8'h5A, 1'b0, got);
    chk("post_rst_miso", {24'd0, got}, 32'h00);
    end_frame();
    pop_check("post_rst_rx", 8'h5A);
`ifdef SPI_SLAVE_STATUS_EN
    chk("underrun_set", {31'd0, tx_und}, 32'd1);
    clear_status();
    chk("underrun_clr", {31'd0, tx_und}, 32'd0);
`endif

    // Overflow: five words with no local pops, fifth is dropped.
    tick();
    for (int w = 1; w <= 5; w++) begin
      send_word(8'(w), 1'b0, got);
    end
    end_frame();
`ifdef SPI_SLAVE_STATUS_EN
    chk("overflow_set", {31'd0, rx_ovf}, 32'd1);
    clear_status();
    chk("overflow_clr", {31'd0, rx_ovf}, 32'd0);
`endif
    for (int w = 1; w <= 4; w++) pop_check("ovf_keep", 8'(w));
    tick();
    chk("ovf_dropped", {31'd0, bus8.rx_valid}, 32'd0);

    // Full RX FIFO with a pop on the completing edge loses nothing.
    for (int w = 0; w < 5; w++) begin
      send_word(8'h10 + 8'(w), (w == 4), got);
    end
    end_frame();
`ifdef SPI_SLAVE_STATUS_EN
    chk("pop_push_no_ovf", {31'd0, rx_ovf}, 32'd0);
    clear_status();
`endif
    for (int w = 1; w <= 4; w++) pop_check("pop_push_keep", 8'h10 + 8'(w));

    // Abort after 3 bits: no RX push, popped TX word lost, next frame aligned.
    push_tx(8'h5C);
    tick(); tick();
    for (int b = 0; b < 3; b++) begin
      tick(); cs_n = 1'b0; mosi = 1'b1;
    end
    end_frame();
    tick();
    chk("abort_no_rx", {31'd0, bus8.rx_valid}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    push_tx(8'h6D);
    tick(); tick();
    send_word(8'hE7, 1'b0, got);
    chk("abort_next_miso", {24'd0, got}, 32'h6D);
    end_frame();
    pop_check("abort_next_rx", 8'hE7);
    tick();
    chk("abort_rx_single", {31'd0, bus8.rx_valid}, 32'd0);

    // 16-bit LSB-first instance.
    tick();
    bus16.tx_valid = 1'b1; bus16.tx_data = 16'h8001;
    tick();
    bus16.tx_valid = 1'b0;
    tick(); tick();
    rxw16 = 16'h00FF;
    for (int b = 0; b < 16; b++) begin
      tick(); cs2_n = 1'b0; mosi2 = rxw16[b]; got16[b] = miso2;
    end
    tick();
    cs2_n = 1'b1;
    chk("w16_miso", {16'd0, got16}, 32'h8001);
    chk("w16_rx_valid", {31'd0, bus16.rx_valid}, 32'd1);
    chk("w16_rx_data", {16'd0, bus16.rx_data}, 32'h00FF);

    // Randomised frames against the queue model.
    ovf_m = 1'b0; und_m = 1'b0;
`ifdef SPI_SLAVE_STATUS_EN
    clear_status();
`endif
    for (int it = 0; it < 40; it++) begin
      int np, nw;
      bit abort;
      np = $urandom_range(0, 3);
      for (int p = 0; p < np; p++) begin
        mw = 8'($urandom);
        tick();
        chk("rnd_tx_ready", {31'd0, bus8.tx_ready}, {31'd0, (txq.size() < 4)});
        push_tx(mw);
        if (txq.size() < 4) txq.push_back(mw);
      end
      tick(); tick();
      nw = $urandom_range(1, 3);
      abort = ($urandom_range(0, 7) == 0);
      for (int w = 0; w < nw; w++) begin
        logic [7:0] exp_m;
        mw = 8'($urandom);
        if (txq.size() > 0) exp_m = txq.pop_front();
        else begin exp_m = 8'h00; und_m = 1'b1; end
        send_word(mw, 1'b0, got);
        chk("rnd_miso", {24'd0, got}, {24'd0, exp_m});
        if (rxq.size() < 4) rxq.push_back(mw);
        else ovf_m = 1'b1;
      end
      if (abort) begin
        if (txq.size() > 0) void'(txq.pop_front());
        else und_m = 1'b1;
        for (int b = 0; b < 2; b++) begin
          tick(); cs_n = 1'b0; mosi = 1'($urandom);
        end
      end
      end_frame();
      tick();
`ifdef SPI_SLAVE_STATUS_EN
      chk("rnd_overflow", {31'd0, rx_ovf}, {31'd0, ovf_m});
      chk("rnd_underrun", {31'd0, tx_und}, {31'd0, und_m});
      clear_status();
`endif
      ovf_m = 1'b0; und_m = 1'b0;
      if ($urandom_range(0, 1) == 1) begin
        while (rxq.size() > 0) pop_check("rnd_rx", rxq.pop_front());
        tick();
        chk("rnd_rx_empty", {31'd0, bus8.rx_valid}, 32'd0);
      end
    end
    while (rxq.size() > 0) pop_check("final_rx", rxq.pop_front());
    tick();
    chk("final_rx_empty", {31'd0, bus8.rx_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
